// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the uart command responder.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StWdata,
    StRegWr,
    StRegRd,
    StRdCap,
    StRdTx,
    StAckTx,
    StNakTx
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for a partially received command frame.
module uart_cmd_timer #(
  parameter int unsigned Cycles = 500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] Limit = CntW'(Cycles - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != Limit) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_expired = i_en && (r_cnt == Limit);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses command frames from the uart RX FIFO, drives a simple register bus and pushes
// responses into the TX FIFO. Define UART_CMD_TIMEOUT_EN to abort frames stalled between bytes.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned AddrWidth     = 8,
  parameter int unsigned RegBytes      = 4,
  parameter int unsigned TimeoutCycles = 500_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_rx_data,
  input  logic [1:0]              i_rx_status,
  input  logic                    i_rx_rdy,
  output logic                    o_rx_req,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_req,
  input  logic                    i_tx_rdy,
  output logic [AddrWidth-1:0]    o_reg_addr,
  output logic [8*RegBytes-1:0]   o_reg_wdata,
  output logic                    o_reg_we,
  output logic                    o_reg_re,
  input  logic [8*RegBytes-1:0]   i_reg_rdata,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int unsigned DataW = 8 * RegBytes;
  localparam int unsigned BufW  = DataW - 8;
  localparam int unsigned CntW  = (RegBytes > 1) ? $clog2(RegBytes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(RegBytes - 1);

  state_e               r_state, w_state_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic                 r_rx_req, w_rx_req_d;
  logic                 r_tx_prev;
  logic                 r_is_wr, w_is_wr_d;
  logic [AddrWidth-1:0] r_addr, w_addr_d;
  logic [AddrWidth-1:0] r_reg_addr, w_reg_addr_d;
  logic [BufW-1:0]      r_wbuf, w_wbuf_d;
  logic [DataW-1:0]     r_reg_wdata, w_reg_wdata_d;
  logic [DataW-1:0]     r_rdata, w_rdata_d;
  logic [DataW-1:0]     w_shift;
  logic                 w_bad, w_pop_st, w_tx_st, w_tmo;

  // New data byte enters at the top; after RegBytes pops the first byte sits at the LSB.
  assign w_shift  = {i_rx_data, r_wbuf};
  assign w_bad    = |i_rx_status;
  assign w_pop_st = r_state inside {StIdle, StAddr, StWdata};
  assign w_tx_st  = r_state inside {StAckTx, StNakTx, StRdTx};

`ifdef UART_CMD_TIMEOUT_EN
  logic w_tmr_en, w_expired;

  assign w_tmr_en = r_state inside {StAddr, StWdata};

  uart_cmd_timer #(
    .Cycles(TimeoutCycles)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (w_tmr_en),
    .i_clr    (r_rx_req),
    .o_expired(w_expired)
  );

  // A pop already in flight wins over an expiry in the same cycle.
  assign w_tmo     = w_expired && !r_rx_req;
  assign o_timeout = w_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TimeoutCycles;
  assign w_tmo        = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_comb begin
    o_tx_req  = w_tx_st && i_tx_rdy && !r_tx_prev;
    o_tx_data = 8'h00;
    unique case (r_state)
      StAckTx: o_tx_data = RSP_ACK;
      StNakTx: o_tx_data = RSP_NAK;
      StRdTx:  o_tx_data = r_rdata[{r_cnt, 3'b000} +: 8];
      default: o_tx_data = 8'h00;
    endcase
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_is_wr_d     = r_is_wr;
    w_addr_d      = r_addr;
    w_reg_addr_d  = r_reg_addr;
    w_wbuf_d      = r_wbuf;
    w_reg_wdata_d = r_reg_wdata;
    w_rdata_d     = r_rdata;
    w_rx_req_d    = w_pop_st && !r_rx_req && i_rx_rdy && !w_tmo;

    unique case (r_state)
      StIdle: begin
        if (r_rx_req) begin
          if (w_bad) begin
            w_state_d = StNakTx;
          end else if (i_rx_data == OP_WRITE) begin
            w_is_wr_d = 1'b1;
            w_state_d = StAddr;
          end else if (i_rx_data == OP_READ) begin
            w_is_wr_d = 1'b0;
            w_state_d = StAddr;
          end else begin
            w_state_d = StNakTx;
          end
        end
      end
      StAddr: begin
        if (w_tmo) begin
          w_state_d = StIdle;
        end else if (r_rx_req) begin
          if (w_bad) begin
            w_state_d = StNakTx;
          end else if (r_is_wr) begin
            w_addr_d  = AddrWidth'(i_rx_data);
            w_cnt_d   = '0;
            w_state_d = StWdata;
          end else begin
            w_reg_addr_d = AddrWidth'(i_rx_data);
            w_state_d    = StRegRd;
          end
        end
      end
      StWdata: begin
        if (w_tmo) begin
          w_state_d = StIdle;
        end else if (r_rx_req) begin
          if (w_bad) begin
            w_state_d = StNakTx;
          end else if (r_cnt == LastCnt) begin
            w_reg_addr_d  = r_addr;
            w_reg_wdata_d = w_shift;
            w_state_d     = StRegWr;
          end else begin
            w_wbuf_d = w_shift[DataW-1:8];
            w_cnt_d  = r_cnt + CntW'(1);
          end
        end
      end
      StRegWr: w_state_d = StAckTx;
      StRegRd: w_state_d = StRdCap;
      StRdCap: begin
        w_rdata_d = i_reg_rdata;
        w_cnt_d   = '0;
        w_state_d = StRdTx;
      end
      StRdTx: begin
        if (o_tx_req) begin
          if (r_cnt == LastCnt) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
      end
      StAckTx, StNakTx: begin
        if (o_tx_req) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rx_req    <= 1'b0;
      r_tx_prev   <= 1'b0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_reg_addr  <= '0;
      r_wbuf      <= '0;
      r_reg_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rx_req    <= w_rx_req_d;
      r_tx_prev   <= o_tx_req;
      r_is_wr     <= w_is_wr_d;
      r_addr      <= w_addr_d;
      r_reg_addr  <= w_reg_addr_d;
      r_wbuf      <= w_wbuf_d;
      r_reg_wdata <= w_reg_wdata_d;
      r_rdata     <= w_rdata_d;
    end
  end

  assign o_rx_req    = r_rx_req;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_we    = (r_state == StRegWr);
  assign o_reg_re    = (r_state == StRegRd);
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO and register-file models, frame-level reference model.
module tb_uart_cmd_responder;

  localparam int unsigned Tmo = 200;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_rx_data;
  logic [1:0]  i_rx_status;
  logic        i_rx_rdy;
  logic        o_rx_req;
  logic [7:0]  o_tx_data;
  logic        o_tx_req;
  logic        i_tx_rdy;
  logic [7:0]  o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic        o_reg_we;
  logic        o_reg_re;
  logic [31:0] i_reg_rdata;
  logic        o_busy;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  uart_cmd_responder #(
    .AddrWidth    (8),
    .RegBytes     (4),
    .TimeoutCycles(Tmo)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_status(i_rx_status),
    .i_rx_rdy   (i_rx_rdy),
    .o_rx_req   (o_rx_req),
    .o_tx_data  (o_tx_data),
    .o_tx_req   (o_tx_req),
    .i_tx_rdy   (i_tx_rdy),
    .o_reg_addr (o_reg_addr),
    .o_reg_wdata(o_reg_wdata),
    .o_reg_we   (o_reg_we),
    .o_reg_re   (o_reg_re),
    .i_reg_rdata(i_reg_rdata),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  int checks = 0;
  int failures = 0;

  logic [9:0]  rxq[$];
  int          rd_ptr = 0;
  int          tx_mode = 0;
  logic [31:0] tb_mem[256];
  logic [31:0] mmem[256];
  logic [7:0]  frame[$];
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  tx_log[$];
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          tmo_cnt = 0;
  logic        tmo_ok = 1'b0;
  logic        prev_rx, prev_tx;

  assign i_reg_rdata = tb_mem[o_reg_addr];

  function automatic logic [31:0] init_val(int a);
    logic [7:0] b;
    b = a[7:0];
    if (b == 8'h20) return 32'hCAFEBABE;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level reference: decides responses from the sequence of consumed bytes.
  task automatic model_byte(logic [7:0] b, logic [1:0] st);
    logic [31:0] d;
    if (st != 2'b00) begin
      exp_tx.push_back(8'h15);
      frame.delete();
      return;
    end
    frame.push_back(b);
    if (frame[0] != 8'h57 && frame[0] != 8'h52) begin
      exp_tx.push_back(8'h15);
      frame.delete();
    end else if (frame[0] == 8'h52 && frame.size() == 2) begin
      exp_rd.push_back(frame[1]);
      d = mmem[frame[1]];
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
      frame.delete();
    end else if (frame[0] == 8'h57 && frame.size() == 6) begin
      d = {frame[5], frame[4], frame[3], frame[2]};
      exp_wr.push_back({frame[1], d});
      mmem[frame[1]] = d;
      exp_tx.push_back(8'h06);
      frame.delete();
    end
  endtask

  // RX FIFO model (first-word fall-through) and TX ready driver.
  always @(posedge i_clk) begin
    if (!i_rst_n) rd_ptr = rxq.size();
    else if (o_rx_req && rd_ptr < rxq.size()) rd_ptr++;
    #1;
    if (rd_ptr < rxq.size()) begin
      i_rx_rdy = 1'b1;
      {i_rx_status, i_rx_data} = rxq[rd_ptr];
    end else begin
      i_rx_rdy = 1'b0;
      i_rx_status = 2'b00;
      i_rx_data = 8'h00;
    end
    case (tx_mode)
      0: i_tx_rdy = 1'b1;
      1: i_tx_rdy = ($urandom_range(0, 3) != 0);
      default: i_tx_rdy = 1'b0;
    endcase
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      for (int a = 0; a < 256; a++) begin
        tb_mem[a] = init_val(a);
        mmem[a] = init_val(a);
      end
      frame.delete();
      exp_tx.delete();
      exp_wr.delete();
      exp_rd.delete();
      prev_rx = 1'b0;
      prev_tx = 1'b0;
      chk("reset_outputs", {o_rx_req, o_tx_req, o_reg_we, o_reg_re, o_busy, o_timeout,
                            o_tx_data, o_reg_addr, o_reg_wdata}, 64'h0);
    end else begin
      if (o_rx_req) begin
        chk("rx_req_when_rdy", i_rx_rdy, 1);
        chk("rx_req_gap", prev_rx, 0);
        model_byte(i_rx_data, i_rx_status);
      end
      if (o_tx_req) begin
        chk("tx_req_when_rdy", i_tx_rdy, 1);
        chk("tx_req_gap", prev_tx, 0);
        if (exp_tx.size() == 0) chk("tx_unexpected", {8'h1, o_tx_data}, 0);
        else chk("tx_data", o_tx_data, exp_tx.pop_front());
        tx_log.push_back(o_tx_data);
      end
      if (o_reg_we) begin
        if (exp_wr.size() == 0) chk("we_unexpected", {o_reg_addr, o_reg_wdata}, 0);
        else chk("we_addr_data", {o_reg_addr, o_reg_wdata}, exp_wr.pop_front());
        tb_mem[o_reg_addr] = o_reg_wdata;
        we_cnt++;
      end
      if (o_reg_re) begin
        if (exp_rd.size() == 0) chk("re_unexpected", {8'h1, o_reg_addr}, 0);
        else chk("re_addr", o_reg_addr, exp_rd.pop_front());
        re_cnt++;
      end
`ifdef UART_CMD_TIMEOUT_EN
      if (o_timeout) begin
        chk("timeout_allowed", tmo_ok, 1);
        frame.delete();
        tmo_cnt++;
      end
`else
      chk("timeout_tied_low", o_timeout, 0);
`endif
      prev_rx = o_rx_req;
      prev_tx = o_tx_req;
    end
  end

  task automatic send(logic [7:0] b, logic [1:0] st);
    @(posedge i_clk);
    #3;
    rxq.push_back({st, b});
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (!(rd_ptr == rxq.size() && exp_tx.size() == 0 && exp_wr.size() == 0 &&
             exp_rd.size() == 0 && frame.size() == 0 && !o_busy) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_idle_in_budget"}, (n < budget), 1);
  endtask

  task automatic chk_log(string name, int start, int n, logic [63:0] exp);
    logic [63:0] got = '0;
    for (int i = start; i < tx_log.size(); i++) got = (got << 8) | 64'(tx_log[i]);
    chk({name, "_len"}, tx_log.size() - start, n);
    chk({name, "_bytes"}, got, exp);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, w0, r0;
    i_rst_n = 1'b0;
    i_rx_rdy = 1'b0;
    i_rx_data = 8'h00;
    i_rx_status = 2'b00;
    i_tx_rdy = 1'b1;
    repeat (4) @(posedge i_clk);
    #3 i_rst_n = 1'b1;

    // 1: write frame
    s = tx_log.size(); w0 = we_cnt;
    send(8'h57, 0); send(8'h10, 0); send(8'h78, 0);
    send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
    wait_idle("t1", 500);
    chk_log("t1_tx", s, 1, 64'h06);
    chk("t1_we_count", we_cnt - w0, 1);
    chk("t1_mem", tb_mem[8'h10], 32'h12345678);

    // 2: read frame
    s = tx_log.size(); r0 = re_cnt;
    send(8'h52, 0); send(8'h20, 0);
    wait_idle("t2", 500);
    chk_log("t2_tx", s, 4, 64'hBEBAFECA);
    chk("t2_re_count", re_cnt - r0, 1);

    // 3: unknown opcode then read
    s = tx_log.size(); r0 = re_cnt; w0 = we_cnt;
    send(8'h41, 0);
    wait_idle("t3a", 500);
    chk("t3_no_strobe", {we_cnt - w0, re_cnt - r0}, 0);
    send(8'h52, 0); send(8'h10, 0);
    wait_idle("t3b", 500);
    chk_log("t3_tx", s, 5, 64'h15_78563412);

    // 4: status error on the address byte
    s = tx_log.size(); w0 = we_cnt;
    send(8'h57, 0); send(8'h10, 2'b01);
    wait_idle("t4a", 500);
    chk("t4_no_we", we_cnt - w0, 0);
    send(8'h52, 0); send(8'h20, 0);
    wait_idle("t4b", 500);
    chk_log("t4_tx", s, 5, 64'h15_BEBAFECA);

    // 5: TX back-pressure during a read response
    s = tx_log.size();
    tx_mode = 2;
    send(8'h52, 0); send(8'h20, 0);
    repeat (50) @(posedge i_clk);
    chk("t5_no_tx_while_stalled", tx_log.size() - s, 0);
    tx_mode = 0;
    wait_idle("t5", 500);
    chk_log("t5_tx", s, 4, 64'hBEBAFECA);

    // Reset in the middle of a write frame
    s = tx_log.size(); w0 = we_cnt;
    send(8'h57, 0); send(8'h10, 0); send(8'hAA, 0);
    repeat (12) @(posedge i_clk);
    do_reset();
    repeat (20) @(posedge i_clk);
    chk("rst_mid_no_we", we_cnt - w0, 0);
    chk("rst_mid_no_tx", tx_log.size() - s, 0);
    send(8'h52, 0); send(8'h20, 0);
    wait_idle("rst_after", 500);
    chk_log("rst_after_tx", s, 4, 64'hBEBAFECA);

    // Randomised frames with TX back-pressure
    tx_mode = 1;
    for (int f = 0; f < 60; f++) begin
      int kind, bad_idx, len;
      logic [7:0] bytes[6];
      kind = $urandom_range(0, 9);
      bytes[0] = (kind < 4) ? 8'h57 : 8'h52;
      bytes[1] = 8'h40 + 8'($urandom_range(0, 7));
      for (int i = 2; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
      len = (kind < 4) ? 6 : 2;
      if (kind == 8) begin
        bytes[0] = 8'($urandom_range(0, 255));
        if (bytes[0] == 8'h57 || bytes[0] == 8'h52) bytes[0] = 8'h00;
        len = 1;
      end
      bad_idx = (kind == 9) ? $urandom_range(0, 5) : -1;
      if (kind == 9) bytes[0] = 8'h57;
      if (kind == 9) len = 6;
      for (int i = 0; i < len; i++) send(bytes[i], (i == bad_idx) ? 2'b10 : 2'b00);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(posedge i_clk);
    end
    // Complete any frame left open by corrupted-frame leftovers
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 2000 && rd_ptr != rxq.size(); n++) @(negedge i_clk);
      repeat (2) @(negedge i_clk);
      if (frame.size() != 0) send(8'h00, 0);
    end
    wait_idle("rand", 20000);
    tx_mode = 0;
    chk("rand_drained", {32'(exp_tx.size()), 16'(exp_wr.size()), 16'(exp_rd.size())}, 0);

`ifdef UART_CMD_TIMEOUT_EN
    // 6: partial frame abandoned by the inter-byte timeout
    s = tx_log.size(); w0 = we_cnt; r0 = tmo_cnt;
    tmo_ok = 1'b1;
    send(8'h57, 0); send(8'h10, 0);
    repeat (Tmo + 50) @(posedge i_clk);
    tmo_ok = 1'b0;
    @(negedge i_clk);
    chk("t6_timeout_pulses", tmo_cnt - r0, 1);
    chk("t6_no_tx", tx_log.size() - s, 0);
    chk("t6_no_we", we_cnt - w0, 0);
    chk("t6_idle", o_busy, 0);
    send(8'h52, 0); send(8'h20, 0);
    wait_idle("t6_after", 500);
    chk_log("t6_after_tx", s, 4, 64'hBEBAFECA);
`endif

    chk("final_busy", o_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
